designbench_run_ctrl: RTL



---
 rtl/designbench_run_ctrl_if.sv | 37 +++
 rtl/designbench_run_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/designbench_run_ctrl_if.sv
// rtl/designbench_run_ctrl_if.sv - harness-side bundle of the benchmark run sequencer
//
// Signals:
//   start      harness -> ctrl   begin a run (honoured only in IDLE)
//   dut_done   harness -> ctrl   DUT completion level (honoured only in MEASURE)
//   dut_rst_n  ctrl -> harness   active-low reset for the DUT
//   measuring  ctrl -> harness   high while in MEASURE
//   trace_on   ctrl -> harness   waveform dump enable
//   finished   ctrl -> harness   high in DONE
//   timed_out  ctrl -> harness   MEASURE ended on the cycle limit
//   cycles     ctrl -> harness   measured cycle count (CNT_W bits)
//   state      ctrl -> harness   IDLE=0 RESET=1 WARMUP=2 MEASURE=3 DRAIN=4 DONE=5
// Modports: master = harness/testbench side, slave = run controller side.

interface designbench_run_ctrl_if #(
    parameter int CNT_W = 64
);
    logic             start;
    logic             dut_done;
    logic             dut_rst_n;
    logic             measuring;
    logic             trace_on;
    logic             finished;
    logic             timed_out;
    logic [CNT_W-1:0] cycles;
    logic [2:0]       state;

    modport master (
        output start, dut_done,
        input  dut_rst_n, measuring, trace_on, finished, timed_out, cycles, state
    );

    modport slave (
        input  start, dut_done,
        output dut_rst_n, measuring, trace_on, finished, timed_out, cycles, state
    );
endinterface

// File: rtl/designbench_run_ctrl.sv
// rtl/designbench_run_ctrl.sv - benchmark run sequencer: DUT reset, warmup, measured window, drain, done
//
// Ports:
//   clk    main benchmark clock
//   rst_n  asynchronous active-low reset
//   bus    designbench_run_ctrl_if.slave (start/dut_done in; dut_rst_n, measuring,
//          trace_on, finished, timed_out, cycles, state out; all outputs registered)
// Optional feature macro: DESIGNBENCH_TRACE_WINDOW_EN
//   defined   -> trace_on limited to measured indices [TRACE_START, TRACE_START+TRACE_LEN)
//   undefined -> trace_on follows measuring

module designbench_run_ctrl #(
    parameter int                CNT_W         = 64,
    parameter longint unsigned   RESET_CYCLES  = 16,
    parameter longint unsigned   WARMUP_CYCLES = 100,
    parameter longint unsigned   MAX_CYCLES    = 1000000,
    parameter longint unsigned   DRAIN_CYCLES  = 8,
    parameter longint unsigned   TRACE_START   = 0,
    parameter longint unsigned   TRACE_LEN     = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    designbench_run_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_WARMUP  = 3'd2,
        S_MEASURE = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Parameter sanity: zero-length RESET/MEASURE phases are meaningless, and every
    // length must be representable in the counter width.
    if (RESET_CYCLES < 64'd1) begin : g_bad_reset
        $error("RESET_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 64'd1) begin : g_bad_max
        $error("MAX_CYCLES must be >= 1");
    end
    if (CNT_W < 64) begin : g_fit
        if (((RESET_CYCLES | WARMUP_CYCLES | MAX_CYCLES | DRAIN_CYCLES
              | TRACE_START | TRACE_LEN) >> CNT_W) != 64'd0) begin : g_too_wide
            $error("length parameter does not fit in CNT_W bits");
        end
    end

    localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 64'd1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 64'd1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 64'd1);
    localparam logic [CNT_W-1:0] MAX_COUNT   = CNT_W'(MAX_CYCLES);
    localparam bit               SKIP_WARMUP = (WARMUP_CYCLES == 64'd0);
    localparam bit               SKIP_DRAIN  = (DRAIN_CYCLES == 64'd0);

    state_t           state_q;
    state_t           next_state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] cycles_inc;
    logic             hit_max;
    logic             trace_hit;
    logic             dut_rst_n_q;
    logic             measuring_q;
    logic             trace_on_q;
    logic             finished_q;
    logic             timed_out_q;

    // cycles counts the current MEASURE cycle on its closing edge, so the limit
    // is reached when the incremented value equals MAX_CYCLES.
    assign cycles_inc = cycles_q + ONE;
    assign hit_max    = (cycles_inc == MAX_COUNT);

`ifdef DESIGNBENCH_TRACE_WINDOW_EN
    localparam logic [CNT_W-1:0] TRACE_FIRST = CNT_W'(TRACE_START);
    localparam logic [CNT_W:0]   TRACE_END   = {1'b0, TRACE_FIRST} + {1'b0, CNT_W'(TRACE_LEN)};

    // Index of the MEASURE cycle that follows this edge: either the first one
    // (cycles still 0) or the one after the current cycle.
    logic [CNT_W-1:0] trace_idx;
    assign trace_idx = (state_q == S_MEASURE) ? cycles_inc : cycles_q;
    assign trace_hit = (trace_idx >= TRACE_FIRST) && ({1'b0, trace_idx} < TRACE_END);
`else
    assign trace_hit = 1'b1;
`endif

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) next_state = S_RESET;
            S_RESET:   if (phase_cnt == RESET_LAST)
                           next_state = SKIP_WARMUP ? S_MEASURE : S_WARMUP;
            S_WARMUP:  if (phase_cnt == WARMUP_LAST) next_state = S_MEASURE;
            // dut_done and the limit are a single exit condition; timed_out
            // below gives dut_done priority when both land together.
            S_MEASURE: if (bus.dut_done || hit_max)
                           next_state = SKIP_DRAIN ? S_DONE : S_DRAIN;
            S_DRAIN:   if (phase_cnt == DRAIN_LAST) next_state = S_DONE;
            S_DONE:    next_state = S_DONE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_cnt   <= '0;
            cycles_q    <= '0;
            dut_rst_n_q <= 1'b0;
            measuring_q <= 1'b0;
            trace_on_q  <= 1'b0;
            finished_q  <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q <= next_state;

            if (next_state != state_q) begin
                phase_cnt <= '0;
            end else if (state_q == S_RESET || state_q == S_WARMUP || state_q == S_DRAIN) begin
                phase_cnt <= phase_cnt + ONE;
            end

            if (state_q == S_MEASURE) begin
                cycles_q    <= cycles_inc;
                timed_out_q <= hit_max && !bus.dut_done;
            end

            dut_rst_n_q <= !(next_state == S_IDLE || next_state == S_RESET);
            measuring_q <= (next_state == S_MEASURE);
            trace_on_q  <= (next_state == S_MEASURE) && trace_hit;
            finished_q  <= (next_state == S_DONE);
        end
    end

    assign bus.state     = state_q;
    assign bus.dut_rst_n = dut_rst_n_q;
    assign bus.measuring = measuring_q;
    assign bus.trace_on  = trace_on_q;
    assign bus.finished  = finished_q;
    assign bus.timed_out = timed_out_q;
    assign bus.cycles    = cycles_q;

endmodule
